// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line in, received byte and status out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dataout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output dataout, valid, parity_err, frame_err, busy);
  modport slave  (output rx, input dataout, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with 2-of-3 majority sampling per bit.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter logic PARITY_MODE = 1'b0
) (
  input logic        clk,
  input logic        rst,
  uart_rx_if.master  bus
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state;
  logic       rx_m;
  logic       rx_s;
  logic       rx_p;
  logic [3:0] tick;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       s7;
  logic       s8;
  logic       maj;
  logic       in_frame;

`ifdef UART_RX_PARITY_EN
  logic       par_bit;
`else
  logic       unused_parity_mode;
  assign unused_parity_mode = PARITY_MODE;
`endif

  assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign in_frame = (state != ARM) && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      rx_p           <= 1'b0;
      state          <= ARM;
      tick           <= 4'd0;
      idx            <= 3'd0;
      shreg          <= 8'd0;
      s7             <= 1'b0;
      s8             <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
`endif
      bus.dataout    <= 8'd0;
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      rx_m      <= bus.rx;
      rx_s      <= rx_m;
      rx_p      <= rx_s;
      bus.valid <= 1'b0;

      if (in_frame) begin
        tick <= tick + 4'd1;
        if (tick == 4'd7) s7 <= rx_s;
        if (tick == 4'd8) s8 <= rx_s;
      end

      case (state)
        // Synchronizer flops reset high, so leave only once a high has come through from the pin.
        ARM: if (rx_m && rx_s && rx_p) state <= IDLE;
        IDLE: begin
          if (rx_p && !rx_s) begin
            tick     <= 4'd0;
            state    <= START;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (tick == 4'd9 && maj) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (tick == 4'd15) begin
            state <= DATA;
            idx   <= 3'd0;
          end
        end
        DATA: begin
          if (tick == 4'd9) shreg[idx] <= maj;
          if (tick == 4'd15) begin
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == 4'd9)  par_bit <= maj;
          if (tick == 4'd15) state   <= STOP;
        end
`endif
        STOP: begin
          if (tick == 4'd9) begin
            bus.dataout    <= shreg;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= par_bit ^ (^shreg) ^ PARITY_MODE;
`else
            bus.parity_err <= 1'b0;
`endif
            bus.frame_err  <= ~maj;
            bus.valid      <= 1'b1;
            bus.busy       <= 1'b0;
            // Good stop returns to IDLE mid-bit so an immediately following start is caught.
            state          <= maj ? IDLE : ARM;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
